// File: rtl/vga_sync_gen.sv
// Raster timing generator: per-axis segment FSMs walk pixel/line counters and a
// registered decode stage produces sync, display-enable, coordinates, strobes and a frame count.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10,
  parameter int FRAME_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter value of each segment; a zero-length porch collapses onto its predecessor.
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_END   = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_END   = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic H_FP_NIL = (H_FP == 0);
  localparam logic H_BP_NIL = (H_BP == 0);
  localparam logic V_FP_NIL = (V_FP == 0);
  localparam logic V_BP_NIL = (V_BP == 0);

  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_sync_gen: sync width must be at least 1");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_width
    $error("vga_sync_gen: line or frame total does not fit in CW bits");
  end

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_FP     = 2'd1,
    S_SYNC   = 2'd2,
    S_BP     = 2'd3
  } seg_t;

  function automatic seg_t seg_next(
    input seg_t          s,
    input logic [CW-1:0] c,
    input logic [CW-1:0] act_end,
    input logic [CW-1:0] fp_end,
    input logic [CW-1:0] sync_end,
    input logic [CW-1:0] last_c,
    input logic          fp_nil,
    input logic          bp_nil
  );
    seg_t n;
    n = s;
    case (s)
      S_ACTIVE: if (c == act_end)  n = fp_nil ? S_SYNC : S_FP;
      S_FP:     if (c == fp_end)   n = S_SYNC;
      S_SYNC:   if (c == sync_end) n = bp_nil ? S_ACTIVE : S_BP;
      S_BP:     if (c == last_c)   n = S_ACTIVE;
      default:                     n = S_ACTIVE;
    endcase
    return n;
  endfunction

  // Stage p0: raster position and segment state
  logic [CW-1:0] h_p0, v_p0;
  logic [CW-1:0] h_nxt, v_nxt;
  seg_t          hst_p0, vst_p0;
  seg_t          hst_nxt, vst_nxt;
  logic          h_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_p0   <= '0;
      v_p0   <= '0;
      hst_p0 <= S_ACTIVE;
      vst_p0 <= S_ACTIVE;
    end else if (en) begin
      h_p0   <= h_nxt;
      v_p0   <= v_nxt;
      hst_p0 <= hst_nxt;
      vst_p0 <= vst_nxt;
    end
  end

  always_comb begin
    h_wrap  = (h_p0 == H_LAST);
    h_nxt   = h_wrap ? '0 : h_p0 + 1'b1;
    v_nxt   = v_p0;
    vst_nxt = vst_p0;
    hst_nxt = seg_next(hst_p0, h_p0, H_ACT_END, H_FP_END, H_SYNC_END, H_LAST,
                       H_FP_NIL, H_BP_NIL);
    if (h_wrap) begin
      v_nxt   = (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
      vst_nxt = seg_next(vst_p0, v_p0, V_ACT_END, V_FP_END, V_SYNC_END, V_LAST,
                         V_FP_NIL, V_BP_NIL);
    end
  end

  // Stage p1: registered decode of the position held before the edge
  logic               hsync_p1, vsync_p1, de_p1;
  logic [CW-1:0]      x_p1, y_p1;
  logic               line_start_p1, frame_start_p1;
  logic [FRAME_W-1:0] frame_cnt_p1;
  logic               frame_seen_p1;
  logic               at_origin;

  assign at_origin = (h_p0 == '0) && (v_p0 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p1       <= ~SYNC_ON;
      vsync_p1       <= ~SYNC_ON;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      frame_cnt_p1   <= '0;
      frame_seen_p1  <= 1'b0;
    end else if (en) begin
      hsync_p1       <= (hst_p0 == S_SYNC) ? SYNC_ON : ~SYNC_ON;
      vsync_p1       <= (vst_p0 == S_SYNC) ? SYNC_ON : ~SYNC_ON;
      de_p1          <= (hst_p0 == S_ACTIVE) && (vst_p0 == S_ACTIVE);
      x_p1           <= h_p0;
      y_p1           <= v_p0;
      line_start_p1  <= (h_p0 == '0);
      frame_start_p1 <= at_origin;
      // The frame that starts right after reset is frame 0; later starts count up.
      if (at_origin) begin
        if (frame_seen_p1) frame_cnt_p1 <= frame_cnt_p1 + 1'b1;
        frame_seen_p1 <= 1'b1;
      end
    end else begin
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign de          = de_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign line_start  = line_start_p1;
  assign frame_start = frame_start_p1;
  assign frame_cnt   = frame_cnt_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: small 8x6 raster plus a default 640x480 instance.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst, en, en_d;
  always #5 clk = ~clk;

  logic       hs, vs, de, ls, fs;
  logic [9:0] x, y;
  logic [5:0] fc;
  logic       hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [5:0] fc_d;

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hsync(hs), .vsync(vs), .de(de),
    .x(x), .y(y), .line_start(ls), .frame_start(fs), .frame_cnt(fc)
  );

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .en(en_d), .hsync(hs_d), .vsync(vs_d), .de(de_d),
    .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs on the k-th enabled edge after reset release (k starts at 1).
  task automatic check_edge(input int k);
    int h, v, f;
    h = (k - 1) % 8;
    v = ((k - 1) / 8) % 6;
    f = ((k - 1) / 48) % 64;
    check($sformatf("de@%0d", k), de, (h < 4) && (v < 3));
    check($sformatf("hsync@%0d", k), hs, !((h >= 5) && (h < 7)));
    check($sformatf("vsync@%0d", k), vs, (v != 4));
    check($sformatf("x@%0d", k), x, h);
    check($sformatf("y@%0d", k), y, v);
    check($sformatf("line_start@%0d", k), ls, (h == 0));
    check($sformatf("frame_start@%0d", k), fs, (h == 0) && (v == 0));
    check($sformatf("frame_cnt@%0d", k), fc, f);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hsync"}, hs, 1);
    check({tag, "_vsync"}, vs, 1);
    check({tag, "_de"}, de, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_ls"}, ls, 0);
    check({tag, "_fs"}, fs, 0);
    check({tag, "_fc"}, fc, 0);
  endtask

  initial begin
    int hd;
    rst  = 1'b1;
    en   = 1'b1;
    en_d = 1'b0;
    // Reset held with the clock running
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_state($sformatf("rst_hold%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;

    // Full frames, frame counter and its wrap after 64 frames
    for (int k = 1; k <= 3075; k++) begin
      tick();
      check_edge(k);
    end
    check("wrap_fs", fs, 0);
    check("wrap_x", x, 2);

    // Freeze while x=2
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("frz_x%0d", i), x, 2);
      check($sformatf("frz_de%0d", i), de, 1);
      check($sformatf("frz_hs%0d", i), hs, 1);
      check($sformatf("frz_ls%0d", i), ls, 0);
      check($sformatf("frz_fs%0d", i), fs, 0);
    end
    en = 1'b1;
    for (int k = 3076; k <= 3081; k++) begin
      tick();
      check_edge(k);
    end

    // Dropping en right on a line_start must clear the strobe
    en = 1'b0;
    tick();
    check("ls_clear", ls, 0);
    check("ls_clear_x", x, 0);
    check("ls_clear_y", y, 1);
    en = 1'b1;
    for (int k = 3082; k <= 3086; k++) begin
      tick();
      check_edge(k);
    end
    check("pre_arst_hs", hs, 0);

    // Asynchronous reset in the middle of hsync, between edges
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("arst");
    tick();
    tick();
    check_reset_state("arst_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_edge(k);
    end

    // Default 640x480 timing, first two lines
    @(negedge clk);
    en_d = 1'b1;
    for (int k = 1; k <= 1601; k++) begin
      tick();
      hd = (k - 1) % 800;
      check($sformatf("d_ls@%0d", k), ls_d, (hd == 0));
      check($sformatf("d_hs@%0d", k), hs_d, !((hd >= 656) && (hd < 752)));
      check($sformatf("d_de@%0d", k), de_d, (hd < 640));
      check($sformatf("d_x@%0d", k), x_d, hd);
      check($sformatf("d_y@%0d", k), y_d, (k - 1) / 800);
      check($sformatf("d_vs@%0d", k), vs_d, 1);
      check($sformatf("d_fs@%0d", k), fs_d, (k == 1));
      check($sformatf("d_fc@%0d", k), fc_d, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
